instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Parametrised, registered instruction-decode stage for the Harvard core. Sits between instruction fetch and the register file / ALU / data-memory issue logic.
- Splits each fetched instruction word into opcode, register, immediate and address fields.
- Generates per-class read/write enables and flags illegal opcodes.
- Decouples fetch from issue with a valid/ready handshake and a two-entry skid buffer.

Parameters:
- INSTR_W, 32, instruction word width.
- OPC_W, 6, opcode width, located at [INSTR_W-1 -: OPC_W].
- REG_W, 5, register-specifier width.
- IMM_W, 16, immediate width, located at [IMM_W-1:0].
- ADDR_W, 8, data-memory address width.
- NUM_ALU, 14, number of ALU opcodes, starting at opcode 4.
- CNT_W, 8, illegal-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  INSTR_W  instruction word.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  issue accepts the entry.
- out_opcode  out  OPC_W  raw opcode.
- out_alu_sel  out  4  opcode-4 for ALU ops, else 0.
- out_rd2, out_rd1, out_rs2, out_rs1  out  REG_W each  register fields.
- out_imm  out  IMM_W  immediate.
- out_addr  out  ADDR_W  memory address.
- out_we2, out_we1  out  1 each  register-file write enables.
- out_re2, out_re1  out  1 each  register-file read enables.
- out_mem_rd, out_mem_wr  out  1 each  data-memory access.
- out_illegal  out  1  opcode not in map.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Field positions, with T = INSTR_W-OPC_W:
  - rd2 = [T-1 -: REG_W]
  - rd1 = [T-REG_W-1 -: REG_W]
  - rs2 = [2*REG_W-1 : REG_W]
  - rs1 = [REG_W-1:0]
  - imm = [IMM_W-1:0]
- Opcode map. Every field not used by the opcode is driven 0.
  - Opcode 0, LDI: rd2, imm; we2=1.
  - Opcode 1, MOV: rd2, rs2 taken from [REG_W-1:0]; we2=1, re2=1.
  - Opcode 2, LD: rd2, addr=[ADDR_W-1:0]; we2=1, mem_rd=1.
  - Opcode 3, ST: addr=[T-1 -: ADDR_W], rs2 taken from [REG_W-1:0]; re2=1, mem_wr=1.
  - Opcodes 4 to 4+NUM_ALU-1, ALU: rd2, rd1, rs2, rs1 all valid; we2=we1=re2=re1=1; alu_sel = opcode-4.
  - Any other opcode: illegal=1, all enables 0, fields 0. The entry is still passed downstream.
- Handshake:
  - Input is accepted on in_valid & in_ready.
  - Output transfers on out_valid & out_ready.
  - Latency is 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the main register is free.
- Buffering: a main output register plus one skid register.
  - in_ready is registered and equals "skid empty"; it never depends combinationally on out_ready.
  - If out_ready is low while the main register is full and an input is accepted, the input goes to the skid register and in_ready drops the next cycle.
  - When the main register drains, skid contents move to main and in_ready returns to 1 the next cycle.
  - Simultaneous accept and drain with the skid empty: main is replaced, throughput is 1 per cycle.
  - Order is strictly FIFO; no entry is lost or duplicated.
  - Output fields stay stable while out_valid=1 and out_ready=0.
- Flush:
  - Invalidates both entries on the next edge; out_valid=0 and in_ready=1 in the following cycle.
  - An instruction presented together with flush is discarded and not counted.
  - Flush has priority over every other event.
- illegal_cnt:
  - Increments on acceptance of an illegal opcode, not on output.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush.
- Reset (asynchronous, rst_n low), in any state including mid-stall:
  - out_valid=0, in_ready=1, both entries empty.
  - All output fields and enables 0; illegal_cnt=0.
  - Outputs are held at these values until the first edge after rst_n rises.

Test Plan:
- LDI with out_ready=1: in_instr=0x00601234 -> next cycle out_valid=1, opcode=0, rd2=3, imm=0x1234, we2=1, all other enables 0.
- ALU: in_instr=0x10220064 -> rd2=1, rd1=2, rs2=3, rs1=4, alu_sel=0, we2=we1=re2=re1=1. ST: 0x0E940007 -> addr=0xA5, rs2=7, mem_wr=1, re2=1, we2=0.
- Backpressure: hold out_ready=0 and stream 3 instructions -> first two accepted, in_ready=0 after the second. Then raise out_ready -> entries emerge in order, one per cycle, with no loss.
- Illegal: in_instr=0xFC000000 -> out_illegal=1, all enables 0, illegal_cnt=1. Apply 300 illegal instructions with CNT_W=8 -> illegal_cnt saturates at 255.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged; the flushed instructions never appear.
- Assert rst_n=0 asynchronously mid-stall -> out_valid=0, in_ready=1, illegal_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Registered instruction decoder: splits the fetched word into fields/enables, 1-cycle latency.
// Main register plus one skid entry; in_ready is registered (skid empty) and never combinational on out_ready.
module instr_decode_stage #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int ADDR_W  = 8,
  parameter int NUM_ALU = 14,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [3:0]         out_alu_sel,
  output logic [REG_W-1:0]   out_rd2,
  output logic [REG_W-1:0]   out_rd1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [REG_W-1:0]   out_rs1,
  output logic [IMM_W-1:0]   out_imm,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_we2,
  output logic               out_we1,
  output logic               out_re2,
  output logic               out_re1,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int T = INSTR_W - OPC_W;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [3:0]        alu_sel;
    logic [REG_W-1:0]  rd2;
    logic [REG_W-1:0]  rd1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rs1;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic              we2;
    logic              we1;
    logic              re2;
    logic              re1;
    logic              mem_rd;
    logic              mem_wr;
    logic              illegal;
  } dec_t;

  logic [OPC_W-1:0] w_opc;
  dec_t             w_dec;
  logic             w_acc;

  dec_t             r_main;
  dec_t             r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic [CNT_W-1:0] r_cnt;

  assign w_opc = in_instr[INSTR_W-1 -: OPC_W];

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = w_opc;
    if (w_opc == OPC_W'(0)) begin
      w_dec.rd2 = in_instr[T-1 -: REG_W];
      w_dec.imm = in_instr[IMM_W-1:0];
      w_dec.we2 = 1'b1;
    end else if (w_opc == OPC_W'(1)) begin
      w_dec.rd2 = in_instr[T-1 -: REG_W];
      w_dec.rs2 = in_instr[REG_W-1:0];
      w_dec.we2 = 1'b1;
      w_dec.re2 = 1'b1;
    end else if (w_opc == OPC_W'(2)) begin
      w_dec.rd2    = in_instr[T-1 -: REG_W];
      w_dec.addr   = in_instr[ADDR_W-1:0];
      w_dec.we2    = 1'b1;
      w_dec.mem_rd = 1'b1;
    end else if (w_opc == OPC_W'(3)) begin
      w_dec.addr   = in_instr[T-1 -: ADDR_W];
      w_dec.rs2    = in_instr[REG_W-1:0];
      w_dec.re2    = 1'b1;
      w_dec.mem_wr = 1'b1;
    end else if (w_opc <= OPC_W'(4 + NUM_ALU - 1)) begin
      w_dec.alu_sel = 4'(w_opc - OPC_W'(4));
      w_dec.rd2     = in_instr[T-1 -: REG_W];
      w_dec.rd1     = in_instr[T-REG_W-1 -: REG_W];
      w_dec.rs2     = in_instr[2*REG_W-1:REG_W];
      w_dec.rs1     = in_instr[REG_W-1:0];
      w_dec.we2     = 1'b1;
      w_dec.we1     = 1'b1;
      w_dec.re2     = 1'b1;
      w_dec.re1     = 1'b1;
    end else begin
      w_dec.illegal = 1'b1;
    end
  end

  // Skid full is the only condition that blocks fetch.
  assign in_ready = ~r_skid_vld;
  assign w_acc    = in_valid & ~r_skid_vld & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      if (!r_main_vld || out_ready) begin
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_main_vld <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_main_vld <= w_acc;
          if (w_acc) r_main <= w_dec;
        end
      end else if (w_acc) begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
      end
      if (w_acc && w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_main_vld;
  assign out_opcode  = r_main.opcode;
  assign out_alu_sel = r_main.alu_sel;
  assign out_rd2     = r_main.rd2;
  assign out_rd1     = r_main.rd1;
  assign out_rs2     = r_main.rs2;
  assign out_rs1     = r_main.rs1;
  assign out_imm     = r_main.imm;
  assign out_addr    = r_main.addr;
  assign out_we2     = r_main.we2;
  assign out_we1     = r_main.we1;
  assign out_re2     = r_main.re2;
  assign out_re1     = r_main.re1;
  assign out_mem_rd  = r_main.mem_rd;
  assign out_mem_wr  = r_main.mem_wr;
  assign out_illegal = r_main.illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: queue-based occupancy model plus directed literal checks.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [3:0]  out_alu_sel;
  logic [4:0]  out_rd2, out_rd1, out_rs2, out_rs1;
  logic [15:0] out_imm;
  logic [7:0]  out_addr;
  logic        out_we2, out_we1, out_re2, out_re1, out_mem_rd, out_mem_wr, out_illegal;
  logic [7:0]  illegal_cnt;

  int total = 0;
  int bad   = 0;

  logic [60:0] model_q[$];
  int          mcnt;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_alu_sel(out_alu_sel),
    .out_rd2(out_rd2), .out_rd1(out_rd1), .out_rs2(out_rs2), .out_rs1(out_rs1),
    .out_imm(out_imm), .out_addr(out_addr),
    .out_we2(out_we2), .out_we1(out_we1), .out_re2(out_re2), .out_re1(out_re1),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field signature, enables ordered we2,we1,re2,re1,mem_rd,mem_wr,illegal.
  wire [60:0] dut_sig = {out_opcode, out_alu_sel, out_rd2, out_rd1, out_rs2, out_rs1,
                         out_imm, out_addr, out_we2, out_we1, out_re2, out_re1,
                         out_mem_rd, out_mem_wr, out_illegal};

  function automatic logic [60:0] model(input logic [31:0] w);
    int          o;
    logic [3:0]  alu;
    logic [4:0]  a, b, c, d;
    logic [15:0] imm;
    logic [7:0]  addr;
    logic [6:0]  en;
    o = int'(w / 32'd67108864);
    alu = 4'd0; a = 5'd0; b = 5'd0; c = 5'd0; d = 5'd0; imm = 16'd0; addr = 8'd0;
    if (o == 0) begin
      a = 5'((w / 32'd2097152) % 32'd32); imm = 16'(w % 32'd65536); en = 7'b1000000;
    end else if (o == 1) begin
      a = 5'((w / 32'd2097152) % 32'd32); c = 5'(w % 32'd32); en = 7'b1010000;
    end else if (o == 2) begin
      a = 5'((w / 32'd2097152) % 32'd32); addr = 8'(w % 32'd256); en = 7'b1000100;
    end else if (o == 3) begin
      addr = 8'((w / 32'd262144) % 32'd256); c = 5'(w % 32'd32); en = 7'b0010010;
    end else if (o >= 4 && o < 18) begin
      alu = 4'(o - 4);
      a = 5'((w / 32'd2097152) % 32'd32);
      b = 5'((w / 32'd65536) % 32'd32);
      c = 5'((w / 32'd32) % 32'd32);
      d = 5'(w % 32'd32);
      en = 7'b1111000;
    end else begin
      en = 7'b0000001;
    end
    return {6'(o), alu, a, b, c, d, imm, addr, en};
  endfunction

  task automatic chk(input string nm, input logic [60:0] act, input logic [60:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: up to two held entries, FIFO order, counter on accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      mcnt = 0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit acc = in_valid && (model_q.size() < 2);
      if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(model(in_instr));
        if (in_instr[31:26] >= 6'd18 && mcnt < 255) mcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 61'(out_valid), 61'(model_q.size() > 0));
      chk("m_in_ready", 61'(in_ready), 61'(model_q.size() < 2));
      chk("m_illegal_cnt", 61'(illegal_cnt), 61'(mcnt));
      if (model_q.size() > 0) chk("m_fields", dut_sig, model_q[0]);
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    @(negedge clk); #1;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 61'(out_valid), 61'(0));
    chk("rst_in_ready", 61'(in_ready), 61'(1));
    chk("rst_cnt", 61'(illegal_cnt), 61'(0));
    chk("rst_fields", dut_sig, 61'(0));
    #4 rst_n = 1'b1;

    // LDI
    step(1'b1, 32'h00601234, 1'b1, 1'b0); after_edge();
    chk("ldi_valid", 61'(out_valid), 61'(1));
    chk("ldi_fields", dut_sig, {6'd0, 4'd0, 5'd3, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 7'b1000000});
    // Illegal
    step(1'b1, 32'hFC000000, 1'b1, 1'b0); after_edge();
    chk("ill_fields", dut_sig, {6'd63, 4'd0, 20'd0, 16'd0, 8'd0, 7'b0000001});
    chk("ill_cnt", 61'(illegal_cnt), 61'(1));
    // ALU
    step(1'b1, 32'h10220064, 1'b1, 1'b0); after_edge();
    chk("alu_fields", dut_sig, {6'd4, 4'd0, 5'd1, 5'd2, 5'd3, 5'd4, 16'd0, 8'd0, 7'b1111000});
    // ST
    step(1'b1, 32'h0E940007, 1'b1, 1'b0); after_edge();
    chk("st_fields", dut_sig, {6'd3, 4'd0, 5'd0, 5'd0, 5'd7, 5'd0, 16'd0, 8'hA5, 7'b0010010});
    // Back-to-back stream: MOV, LD, last ALU opcode, first illegal opcode
    step(1'b1, 32'h04A3FFE9, 1'b1, 1'b0);
    step(1'b1, 32'h0BE012C3, 1'b1, 1'b0);
    step(1'b1, 32'h47FFFFFF, 1'b1, 1'b0); after_edge();
    chk("alu17_sel", 61'(out_alu_sel), 61'(13));
    step(1'b1, 32'h48000000, 1'b1, 1'b0); after_edge();
    chk("opc18_illegal", 61'(out_illegal), 61'(1));
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure
    step(1'b1, 32'h00601234, 1'b0, 1'b0);
    step(1'b1, 32'h0E940007, 1'b0, 1'b0); after_edge();
    chk("bp_in_ready_low", 61'(in_ready), 61'(0));
    chk("bp_head_ldi", 61'(out_opcode), 61'(0));
    step(1'b1, 32'h10220064, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0); after_edge();
    chk("bp_second_st", 61'(out_opcode), 61'(3));
    chk("bp_in_ready_back", 61'(in_ready), 61'(1));
    step(1'b1, 32'h10220064, 1'b1, 1'b0); after_edge();
    chk("bp_third_alu", 61'(out_opcode), 61'(4));
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with both entries full and an illegal instruction presented
    step(1'b1, 32'h00601234, 1'b0, 1'b0);
    step(1'b1, 32'h0E940007, 1'b0, 1'b0);
    step(1'b1, 32'hFC000000, 1'b0, 1'b1); after_edge();
    chk("fl_out_valid", 61'(out_valid), 61'(0));
    chk("fl_in_ready", 61'(in_ready), 61'(1));
    step(1'b1, 32'hFC000000, 1'b1, 1'b1); after_edge();
    chk("fl_cnt", 61'(illegal_cnt), 61'(2));
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0); after_edge();
    chk("fl_no_reappear", 61'(out_valid), 61'(0));

    // Saturation
    for (int i = 0; i < 300; i++) step(1'b1, 32'hFC000000, 1'b1, 1'b0);
    after_edge();
    chk("sat_cnt", 61'(illegal_cnt), 61'(255));
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stall
    step(1'b1, 32'h00601234, 1'b0, 1'b0);
    step(1'b1, 32'h0E940007, 1'b0, 1'b0);
    @(negedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 61'(out_valid), 61'(0));
    chk("arst_in_ready", 61'(in_ready), 61'(1));
    chk("arst_cnt", 61'(illegal_cnt), 61'(0));
    chk("arst_fields", dut_sig, 61'(0));
    #1 rst_n = 1'b1;
    step(1'b1, 32'h10220064, 1'b1, 1'b0); after_edge();
    chk("post_rst_alu", 61'(out_opcode), 61'(4));
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
